// File: rtl/stream_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_arbiter: round-robin burst arbiter feeding one registered output stage
// Revision: 1.0
// ----------------------------------------------------------------------------
module stream_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH_BITS = 8,
  parameter int MAX_BURST  = 4,
  parameter int SRC_BITS   = $clog2(NUM_INPUTS)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_INPUTS-1:0]            input_valid,
  output logic [NUM_INPUTS-1:0]            input_ready,
  input  logic [NUM_INPUTS*WIDTH_BITS-1:0] input_data,
  input  logic [NUM_INPUTS-1:0]            input_last,
  output logic                             output_valid,
  input  logic                             output_ready,
  output logic [WIDTH_BITS-1:0]            output_data,
  output logic                             output_last,
  output logic [SRC_BITS-1:0]              output_source
);

  localparam int CNT_BITS = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [SRC_BITS-1:0]   grant_idx;
  logic [SRC_BITS-1:0]   last_grant;
  logic [SRC_BITS-1:0]   rr_idx;
  logic                  rr_found;
  logic [CNT_BITS-1:0]   beat_cnt;
  logic [WIDTH_BITS-1:0] data_arr [NUM_INPUTS];
  logic                  slot_free;
  logic                  accept;
  logic                  burst_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign data_arr[gi] = input_data[gi*WIDTH_BITS +: WIDTH_BITS];
    end
  endgenerate

  // The output register can take a beat when empty or draining this cycle.
  assign slot_free = !output_valid || output_ready;
  assign accept    = (state == GRANT) && input_valid[grant_idx] && slot_free;
  assign burst_end = accept &&
                     (input_last[grant_idx] || (beat_cnt == CNT_BITS'(MAX_BURST - 1)));

  always_comb begin : rr_search
    int unsigned         cand;
    logic [SRC_BITS-1:0] cand_idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_INPUTS; off++) begin
      cand     = (32'(last_grant) + 32'(off)) % 32'(NUM_INPUTS);
      cand_idx = cand[SRC_BITS-1:0];
      if (!rr_found && input_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    input_ready = '0;
    if (state == GRANT) begin
      input_ready[grant_idx] = slot_free;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rr_found)  state_next = GRANT;
      GRANT:   if (burst_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= SRC_BITS'(NUM_INPUTS - 1);
      beat_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (rr_found) begin
          grant_idx <= rr_idx;
          beat_cnt  <= '0;
        end
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (burst_end) begin
          last_grant <= grant_idx;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      output_valid  <= 1'b0;
      output_data   <= '0;
      output_last   <= 1'b0;
      output_source <= '0;
    end else if (accept) begin
      // A new beat overwrites a draining one so a burst streams at full rate.
      output_valid  <= 1'b1;
      output_data   <= data_arr[grant_idx];
      output_last   <= burst_end;
      output_source <= grant_idx;
    end else if (output_valid && output_ready) begin
      output_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
